// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost flags, optional first-word-fall-through and sticky error flags.
module fifo_sync_param #(
    parameter int DATA_WIDTH          = 32,
    parameter int FIFO_DEPTH          = 8,
    parameter int ALMOST_FULL_THRESH  = 6,
    parameter int ALMOST_EMPTY_THRESH = 2,
    parameter int FWFT                = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cs,
    input  logic                          write_en,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          read_en,
    input  logic                          clr_err,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          data_valid,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_empty,
    output logic                          almost_full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_TH   = CW'(ALMOST_FULL_THRESH);
    localparam logic [CW-1:0] AE_TH   = CW'(ALMOST_EMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  acc_rd, acc_wr;
    logic [AW-1:0]         rd_idx;

    // The extra pointer MSB makes the difference span 0..FIFO_DEPTH.
    assign count        = wr_ptr_q - rd_ptr_q;
    assign empty        = (count == '0);
    assign full         = (count == DEPTH_C);
    assign almost_empty = (count <= AE_TH);
    assign almost_full  = (count >= AF_TH);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
    assign rd_idx       = rd_ptr_q[AW-1:0];

    assign acc_rd = cs & read_en & ~empty;
    assign acc_wr = cs & write_en & (~full | acc_rd);

    always_comb begin
        wr_ptr_d = wr_ptr_q + CW'(acc_wr);
        rd_ptr_d = rd_ptr_q + CW'(acc_rd);
        ovf_d    = ovf_q & ~clr_err;
        udf_d    = udf_q & ~clr_err;
        if (cs & write_en & ~acc_wr) ovf_d = 1'b1;
        if (cs & read_en & empty)    udf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (acc_wr) mem_q[wr_ptr_q[AW-1:0]] <= data_in;
    end

    if (FWFT == 0) begin : g_std
        logic [DATA_WIDTH-1:0] dout_q;
        logic                  dv_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                dout_q <= '0;
                dv_q   <= 1'b0;
            end else begin
                dv_q <= acc_rd;
                if (acc_rd) dout_q <= mem_q[rd_idx];
            end
        end

        assign data_out   = dout_q;
        assign data_valid = dv_q;
    end else begin : g_fwft
        // Masking when empty hides stale storage after reset.
        assign data_out   = empty ? '0 : mem_q[rd_idx];
        assign data_valid = ~empty;
    end

endmodule
